button_conditioner: RTL and testbench

//  Conditions the raw, asynchronous, bouncing board push-buttons (KEY[1:0], active-low) before they reach the

---
 rtl/button_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions raw, asynchronous, bouncing push-buttons before they reach the
//   button PIO. Each channel is fully independent and consists of a 2-flop
//   synchronizer, a debounce FSM, and registered one-cycle event pulses for
//   accepted press, accepted release and long press.
//
// Ports
//   clocks_ref_clk_clk      in   system reference clock (only clock)
//   clocks_ref_reset_reset  in   reset, asynchronous assert, active-high
//   key_raw                 in   raw button pins, asynchronous to the clock
//   btn_level               out  debounced state, 1 = pressed
//   btn_press               out  1-cycle pulse on accepted press
//   btn_release             out  1-cycle pulse on accepted release
//   btn_long                out  1-cycle pulse once a press has been held
//                                LONG_PRESS_CYCLES; at most once per press
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BUTTONS         = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic                 clocks_ref_clk_clk,
  input  logic                 clocks_ref_reset_reset,
  input  logic [N_BUTTONS-1:0] key_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_long
);

  // +1 keeps the widths non-zero when DEBOUNCE_CYCLES is 1.
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_PRESS_CYCLES - 1);
  // Raw pin level of a released button; the synchronizer resets to it.
  localparam logic RELEASED_RAW = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_DEB_RELEASE
  } state_t;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic          sample;
    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    // 1 = the synchronized pin currently reads "pressed".
    assign sample = sync2_q ^ ACTIVE_LOW;

    // State register: synchronizer, FSM, counters and output registers.
    always_ff @(posedge clocks_ref_clk_clk or posedge clocks_ref_reset_reset) begin
      if (clocks_ref_reset_reset) begin
        sync1_q     <= RELEASED_RAW;
        sync2_q     <= RELEASED_RAW;
        state_q     <= ST_RELEASED;
        dcnt_q      <= '0;
        lcnt_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        sync1_q     <= key_raw[gi];
        sync2_q     <= sync1_q;
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        lcnt_q      <= lcnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
      end
    end

    // Next-state and counter logic.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      lcnt_d  = lcnt_q;

      // The long-press timer keeps running through a release bounce so a
      // short glitch does not restart the hold time; it saturates.
      if ((state_q == ST_PRESSED || state_q == ST_DEB_RELEASE) && lcnt_q != L_LAST) begin
        lcnt_d = lcnt_q + LW'(1);
      end

      case (state_q)
        ST_RELEASED: begin
          if (sample) begin
            state_d = ST_DEB_PRESS;
            dcnt_d  = '0;
          end
        end
        ST_DEB_PRESS: begin
          if (!sample) begin
            state_d = ST_RELEASED;
          end else if (dcnt_q == D_LAST) begin
            state_d = ST_PRESSED;
            lcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        ST_PRESSED: begin
          if (!sample) begin
            state_d = ST_DEB_RELEASE;
            dcnt_d  = '0;
          end
        end
        ST_DEB_RELEASE: begin
          if (sample) begin
            state_d = ST_PRESSED;
          end else if (dcnt_q == D_LAST) begin
            state_d = ST_RELEASED;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end

    // Output logic; every output is registered, so nothing reaches the
    // ports combinationally from key_raw.
    always_comb begin
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      long_done_d = long_done_q;

      case (state_q)
        ST_DEB_PRESS: begin
          if (sample && dcnt_q == D_LAST) begin
            level_d     = 1'b1;
            press_d     = 1'b1;
            long_done_d = 1'b0;
          end
        end
        ST_PRESSED: begin
          // Only evaluated in PRESSED: a window that expired during a
          // release bounce fires once the bounce returns here, and never
          // after the release has been accepted.
          if (lcnt_q == L_LAST && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end
        ST_DEB_RELEASE: begin
          if (!sample && dcnt_q == D_LAST) begin
            level_d   = 1'b0;
            release_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
    assign btn_long[gi]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          clk;
  logic          rst;
  logic [NB-1:0] key;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a change is accepted once the synchronized sample has
  // disagreed with the debounced level for DEB+1 consecutive edges; a long
  // press is reported once the accepted press has lasted LONG edges.
  logic [NB-1:0] m_s1, m_s2, m_level, m_fired, m_prev;
  int            m_run [NB];
  int            m_held[NB];
  logic [NB-1:0] e_press, e_release, e_long;

  button_conditioner #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b1)
  ) dut (
    .clocks_ref_clk_clk(clk),
    .clocks_ref_reset_reset(rst),
    .key_raw(key),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d got=running required=finished", cyc);
    $fatal(1);
  end

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0; m_fired = '0; m_prev = '0;
    e_press = '0; e_release = '0; e_long = '0;
    for (int c = 0; c < NB; c++) begin
      m_run[c] = 0; m_held[c] = 0;
    end
  endtask

  // Advance one clock edge and update the model; returns #1 after the edge.
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < NB; c++) begin
      logic s;
      s = ~m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = key[c];
      e_press[c] = 1'b0; e_release[c] = 1'b0; e_long[c] = 1'b0;
      if (m_level[c]) begin
        m_held[c]++;
        if (!m_fired[c] && m_held[c] >= LONG && m_prev[c]) begin
          e_long[c] = 1'b1; m_fired[c] = 1'b1;
        end
      end
      if (s != m_level[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DEB + 1) begin
        m_level[c] = ~m_level[c];
        m_run[c]   = 0;
        if (m_level[c]) begin
          e_press[c] = 1'b1; m_held[c] = 0; m_fired[c] = 1'b0;
        end else begin
          e_release[c] = 1'b1;
        end
      end
      m_prev[c] = s;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got=%h required=00", {btn_level, btn_press, btn_release, btn_long});
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    int press_at = 0, press_cnt = 0, ch1_cnt = 0;
    key[0] = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 13) key[0] = 1'b1;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL clean_press cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
      if (btn_press[0]) begin press_cnt++; press_at = i; end
      if (btn_level[1] | btn_press[1] | btn_release[1] | btn_long[1]) ch1_cnt++;
    end
    checks++;
    if (press_at != 7 || press_cnt != 1 || ch1_cnt != 0) begin
      errors++;
      $display("FAIL clean_press_timing got at=%0d cnt=%0d ch1=%0d required at=7 cnt=1 ch1=0",
               press_at, press_cnt, ch1_cnt);
    end
    $display("test_clean_press done press_at=%0d", press_at);
  endtask

  task automatic test_bounce();
    int activity = 0;
    int remaining = 0;
    logic lvl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i >= 30) begin
        key[0] = 1'b1;
      end else begin
        if (remaining == 0) begin
          lvl = ~lvl;
          remaining = int'($urandom_range(1, 3));
        end
        key[0] = lvl;
        remaining--;
      end
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
      if ({btn_level, btn_press, btn_release, btn_long} != 8'h00) activity++;
    end
    checks++;
    if (activity != 0) begin
      errors++;
      $display("FAIL bounce_reject got active_cycles=%0d required=0", activity);
    end
    $display("test_bounce done");
  endtask

  task automatic test_long_press();
    int press_at = 0, long_at = 0, long_cnt = 0, rel_at = 0;
    key[1] = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      if (i == 41) key[1] = 1'b1;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL long_press cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
      if (btn_press[1]) press_at = i;
      if (btn_long[1]) begin long_cnt++; long_at = i; end
      if (btn_release[1]) rel_at = i - 40;
    end
    checks++;
    if (press_at != 7 || long_at != 27 || long_cnt != 1 || rel_at != 7) begin
      errors++;
      $display("FAIL long_press_timing got press=%0d long=%0d cnt=%0d rel=%0d required press=7 long=27 cnt=1 rel=7",
               press_at, long_at, long_cnt, rel_at);
    end
    $display("test_long_press done long_at=%0d", long_at);
  endtask

  task automatic test_release_bounce();
    int np = 0, nr = 0, nl = 0;
    for (int i = 1; i <= 30; i++) begin
      key[0] = (i <= 10) ? 1'b0 : (i <= 12) ? 1'b1 : (i <= 15) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL release_bounce cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
      np += int'(btn_press[0]); nr += int'(btn_release[0]); nl += int'(btn_long[0]);
    end
    checks++;
    if (np != 1 || nr != 1 || nl != 0) begin
      errors++;
      $display("FAIL release_bounce_counts got p=%0d r=%0d l=%0d required p=1 r=1 l=0", np, nr, nl);
    end
    $display("test_release_bounce done");
  endtask

  task automatic test_simultaneous();
    int both = 0;
    key = 2'b00;
    for (int i = 1; i <= 24; i++) begin
      if (i == 11) key = 2'b11;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL simultaneous cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
      if (btn_press == 2'b11 && btn_level == 2'b11 && i == 7) both++;
    end
    checks++;
    if (both != 1) begin
      errors++;
      $display("FAIL simultaneous_press got both_at_7=%0d required=1", both);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    int press_at = 0, dirty = 0;
    key[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (btn_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got level=%b required=1", btn_level[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%h required=00", {btn_level, btn_press, btn_release, btn_long});
    end
    repeat (3) begin
      @(posedge clk); #1;
      if ({btn_level, btn_press, btn_release, btn_long} != 8'h00) dirty++;
    end
    checks++;
    if (dirty != 0) begin
      errors++;
      $display("FAIL reset_hold got active_cycles=%0d required=0", dirty);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
      if (btn_press[0]) press_at = i;
    end
    checks++;
    if (press_at != 7) begin
      errors++;
      $display("FAIL reset_mid_repress got at=%0d required=7", press_at);
    end
    key[0] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    $display("test_reset_mid done press_at=%0d", press_at);
  endtask

  task automatic test_random();
    int hold[NB];
    for (int c = 0; c < NB; c++) hold[c] = 0;
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold[c] == 0) begin
          key[c]  = ~key[c];
          hold[c] = int'($urandom_range(1, 32));
        end
        hold[c]--;
      end
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b required=%b", cyc,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, e_press, e_release, e_long});
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    key = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
